pc_fetch_stage: RTL and testbench

- Fetch stage of the 5-stage MIPS pipeline.
- Holds the PC register and the IF/ID pipeline register.
- Selects the next PC from the sequential path, the branch/jump/jr/epc targets computed in D, or the exception handler. The targets arrive from the next-PC calculator in D.
- Produces pc8_D and the fetched instruction for D, together with the fetch-address exception and delay-slot tags that CP0 consumes later.

---
 rtl/pc_fetch_stage.sv | 96 +++++++++
 tb/tb_pc_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, next-PC selection, fetch-address check and IF/ID register.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_4FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        int_exc,
    input  logic [2:0]  pc_sel,
    input  logic        jump_D,
    input  logic [31:0] br_pc,
    input  logic [31:0] j_pc,
    input  logic [31:0] jr_pc,
    input  logic [31:0] epc,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic [4:0]  exccode_D,
    output logic        bd_D,
    output logic        valid_D
);

    localparam int unsigned W = 32;
    localparam logic [2:0]  SEL_BR   = 3'd1;
    localparam logic [2:0]  SEL_J    = 3'd2;
    localparam logic [2:0]  SEL_JR   = 3'd3;
    localparam logic [2:0]  SEL_ERET = 3'd4;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    logic [W-1:0] pc_plus4;
    logic [W-1:0] pc_plus8;
    logic [W-1:0] next_pc;
    logic         fetch_fault;

    // Sequential/target PC selection and fetch-address legality.
    always_comb begin
        pc_plus4 = pc_F + W'(4);
        pc_plus8 = pc_F + W'(8);
        next_pc  = pc_plus4;
        case (pc_sel)
            SEL_BR:  next_pc = br_pc;
            SEL_J:   next_pc = j_pc;
            SEL_JR:  next_pc = jr_pc;
            default: next_pc = pc_plus4;
        endcase
        fetch_fault = (pc_F[1:0] != 2'b00) || (pc_F < IM_LO) || (pc_F > IM_HI);
    end

    // PC and IF/ID update: reset, exception, stall, eret flush, normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F      <= RESET_PC;
            instr_D   <= '0;
            pc_D      <= '0;
            pc8_D     <= W'(8);
            exccode_D <= EXC_NONE;
            bd_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (int_exc) begin
            pc_F      <= HANDLER_PC;
            instr_D   <= '0;
            pc_D      <= '0;
            pc8_D     <= W'(8);
            exccode_D <= EXC_NONE;
            bd_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (stall) begin
            // Hold everything; a pending redirect is re-presented once the stall drops.
        end else if (pc_sel == SEL_ERET) begin
            // eret has no delay slot, so the word fetched behind it is discarded.
            pc_F      <= epc;
            instr_D   <= '0;
            pc_D      <= '0;
            pc8_D     <= W'(8);
            exccode_D <= EXC_NONE;
            bd_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else begin
            // A faulting fetch still enters D as a nop so CP0 can record its PC.
            pc_F      <= next_pc;
            instr_D   <= fetch_fault ? '0 : instr_i;
            pc_D      <= pc_F;
            pc8_D     <= pc_plus8;
            exccode_D <= fetch_fault ? EXC_ADEL : EXC_NONE;
            bd_D      <= jump_D;
            valid_D   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: directed vectors push expected state, a monitor compares.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        int_exc;
    logic [2:0]  pc_sel;
    logic        jump_D;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic [31:0] jr_pc;
    logic [31:0] epc;
    logic [31:0] instr_i;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic [4:0]  exccode_D;
    logic        bd_D;
    logic        valid_D;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
        logic        v;
        int          id;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_id = 0;

    pc_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .int_exc   (int_exc),
        .pc_sel    (pc_sel),
        .jump_D    (jump_D),
        .br_pc     (br_pc),
        .j_pc      (j_pc),
        .jr_pc     (jr_pc),
        .epc       (epc),
        .instr_i   (instr_i),
        .pc_F      (pc_F),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .exccode_D (exccode_D),
        .bd_D      (bd_D),
        .valid_D   (valid_D)
    );

    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address.
    assign instr_i = 32'hA5A5_0000 ^ pc_F;

    task automatic check32(input string name, input int id, input logic [31:0] got,
                           input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, name, got, want);
        end
    endtask

    // Apply inputs at the falling edge; unselected targets carry distinct decoy values.
    task automatic go(input logic r, input logic s, input logic e, input logic [2:0] sel,
                      input logic jd, input logic [31:0] tgt);
        @(negedge clk);
        reset   = r;
        stall   = s;
        int_exc = e;
        pc_sel  = sel;
        jump_D  = jd;
        br_pc   = (sel == 3'd1) ? tgt : 32'h0000_3A00;
        j_pc    = (sel == 3'd2) ? tgt : 32'h0000_3B00;
        jr_pc   = (sel == 3'd3) ? tgt : 32'h0000_3C00;
        epc     = (sel == 3'd4) ? tgt : 32'h0000_3D00;
    endtask

    // Expected state after the next rising edge.
    task automatic ex(input logic [31:0] pcf, input logic [31:0] ins, input logic [31:0] pcd,
                      input logic [31:0] pc8, input logic [4:0] exc, input logic bd,
                      input logic v);
        exp_t e;
        e.pc_f  = pcf;
        e.instr = ins;
        e.pc    = pcd;
        e.pc8   = pc8;
        e.exc   = exc;
        e.bd    = bd;
        e.v     = v;
        e.id    = step_id;
        step_id++;
        q.push_back(e);
    endtask

    // Monitor: after each rising edge compare DUT state against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check32("pc_F",      e.id, pc_F,              e.pc_f);
                check32("instr_D",   e.id, instr_D,           e.instr);
                check32("pc_D",      e.id, pc_D,              e.pc);
                check32("pc8_D",     e.id, pc8_D,             e.pc8);
                check32("exccode_D", e.id, {27'd0, exccode_D}, {27'd0, e.exc});
                check32("bd_D",      e.id, {31'd0, bd_D},     {31'd0, e.bd});
                check32("valid_D",   e.id, {31'd0, valid_D},  {31'd0, e.v});
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; int_exc = 1'b0; pc_sel = 3'd0; jump_D = 1'b0;
        br_pc = '0; j_pc = '0; jr_pc = '0; epc = '0;

        // Reset state
        go(1, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3000, 32'h0,         32'h0,    32'h8,    5'd0, 0, 0);
        // Sequential fetch
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3004, 32'hA5A5_3000, 32'h3000, 32'h3008, 5'd0, 0, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3008, 32'hA5A5_3004, 32'h3004, 32'h300C, 5'd0, 0, 1);
        // Taken branch; the word at 3008 is the delay slot
        go(0, 0, 0, 3'd1, 1, 32'h3100);       ex(32'h3100, 32'hA5A5_3008, 32'h3008, 32'h3010, 5'd0, 1, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3104, 32'hA5A5_3100, 32'h3100, 32'h3108, 5'd0, 0, 1);
        // Stall for two cycles with a pending j
        go(0, 1, 0, 3'd2, 1, 32'h3200);       ex(32'h3104, 32'hA5A5_3100, 32'h3100, 32'h3108, 5'd0, 0, 1);
        go(0, 1, 0, 3'd2, 1, 32'h3200);       ex(32'h3104, 32'hA5A5_3100, 32'h3100, 32'h3108, 5'd0, 0, 1);
        go(0, 0, 0, 3'd2, 1, 32'h3200);       ex(32'h3200, 32'hA5A5_3104, 32'h3104, 32'h310C, 5'd0, 1, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3204, 32'hA5A5_3200, 32'h3200, 32'h3208, 5'd0, 0, 1);
        // Exception beats stall and jr
        go(0, 1, 1, 3'd3, 0, 32'h3300);       ex(32'h4180, 32'h0,         32'h0,    32'h8,    5'd0, 0, 0);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h4184, 32'hA5A5_4180, 32'h4180, 32'h4188, 5'd0, 0, 1);
        // eret flushes
        go(0, 0, 0, 3'd4, 0, 32'h3010);       ex(32'h3010, 32'h0,         32'h0,    32'h8,    5'd0, 0, 0);
        // Misaligned jr target
        go(0, 0, 0, 3'd3, 1, 32'h3002);       ex(32'h3002, 32'hA5A5_3010, 32'h3010, 32'h3018, 5'd0, 1, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3006, 32'h0,         32'h3002, 32'h300A, 5'd4, 0, 1);
        // Out-of-range jr target
        go(0, 0, 0, 3'd3, 0, 32'h5000);       ex(32'h5000, 32'h0,         32'h3006, 32'h300E, 5'd4, 0, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h5004, 32'h0,         32'h5000, 32'h5008, 5'd4, 0, 1);
        // Upper boundary 4FFC is legal
        go(0, 0, 0, 3'd1, 0, 32'h4FFC);       ex(32'h4FFC, 32'h0,         32'h5004, 32'h500C, 5'd4, 0, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h5000, 32'hA5A5_4FFC, 32'h4FFC, 32'h5004, 5'd0, 0, 1);
        // Below the lower boundary
        go(0, 0, 0, 3'd1, 0, 32'h2FFC);       ex(32'h2FFC, 32'h0,         32'h5000, 32'h5008, 5'd4, 0, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3000, 32'h0,         32'h2FFC, 32'h3004, 5'd4, 0, 1);
        // pc_sel 7 behaves as pc+4
        go(0, 0, 0, 3'd7, 0, 32'h0);          ex(32'h3004, 32'hA5A5_3000, 32'h3000, 32'h3008, 5'd0, 0, 1);
        // Wrap-around of pc+4 and pc+8
        go(0, 0, 0, 3'd2, 0, 32'hFFFF_FFFC);  ex(32'hFFFF_FFFC, 32'hA5A5_3004, 32'h3004, 32'h300C, 5'd0, 0, 1);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h0,    32'h0,         32'hFFFF_FFFC, 32'h4, 5'd4, 0, 1);
        // Reset beats exception mid-sequence
        go(1, 0, 1, 3'd1, 1, 32'h3100);       ex(32'h3000, 32'h0,         32'h0,    32'h8,    5'd0, 0, 0);
        go(0, 1, 0, 3'd0, 0, 32'h0);          ex(32'h3000, 32'h0,         32'h0,    32'h8,    5'd0, 0, 0);
        go(0, 0, 0, 3'd0, 0, 32'h0);          ex(32'h3004, 32'hA5A5_3000, 32'h3000, 32'h3008, 5'd0, 0, 1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
